relu_stream_unit: RTL and testbench
===================================

Name: relu_stream_unit

Overview:
Multi-lane, mode-selectable activation stage sitting between the systolic MAC array result drain and the next layer's input buffer. Generalises the single-lane ReLU cell: LANES results per beat, ReLU / leaky-ReLU / clamped-ReLU / pass modes, signed saturation to DATA_WIDTH, a 2-stage pipeline with valid/ready backpressure, and a wrapping output index with a last-beat flag.

Parameters:
LANES, 2, results processed per beat
DATA_WIDTH, 32, output value width per lane (signed)
RESULT_WIDTH, 64, accumulator result width per lane (signed, two's complement)
INDEX_WIDTH, 34, output index counter width
CELL_AMOUNT, 2, beats per output group; index wraps at CELL_AMOUNT-1
SHIFT_WIDTH, 6, width of leaky-ReLU shift amount

Ports:
clk  in  1  rising-edge clock
reset_n  in  1  asynchronous, active-low reset
input_result  in  LANES*RESULT_WIDTH  lane k at [k*RESULT_WIDTH +: RESULT_WIDTH]
input_valid  in  1  beat present on input_result
input_ready  out  1  unit accepts beat this cycle
mode  in  2  0=ReLU, 1=leaky, 2=clamp, 3=pass; sampled with the beat
shift  in  SHIFT_WIDTH  leaky negative-slope shift; sampled with the beat
cap  in  DATA_WIDTH  clamp ceiling (unsigned, ≤ 2^(DATA_WIDTH-1)-1); sampled with the beat
output_value  out  LANES*DATA_WIDTH  lane k at [k*DATA_WIDTH +: DATA_WIDTH]
output_index  out  INDEX_WIDTH  beat position within group
output_enable  out  1  output beat valid
output_last  out  1  output_enable && output_index==CELL_AMOUNT-1
output_ready  in  1  downstream accepts beat

Behaviour:
- Reset (async assert, sync-released use): both stage valids 0, index counter 0, output_value 0, output_enable 0, output_last 0; in-flight beats discarded. Reset mid-stream drops data; no partial group recovery.
- Handshake: input accepted when input_valid && input_ready; output transferred when output_enable && output_ready.
- Pipeline: S1 = activation, S2 = saturation/output register. s2_load = !s2_valid || output_ready; s1_load = !s1_valid || s2_load; input_ready = s1_load (combinational path from output_ready permitted). Latency 2 cycles with output_ready held high; full throughput 1 beat/cycle.
- Stalls: with output_ready low, S2 holds value/enable/index stable; S1 fills; then input_ready drops. No beat lost or duplicated.
- S1 per lane, x signed RESULT_WIDTH: mode0: x<0 → 0 else x. mode1: x<0 → x >>> shift (arithmetic, shift ≥ RESULT_WIDTH-1 gives -1 for negative x) else x. mode2: x<0 → 0, x>cap → cap, else x. mode3: x.
- S2 per lane: saturate signed to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1]; in-range values truncated losslessly.
- output_value forced 0 when output_enable low.
- Index: output_index shows counter; counter increments on each output transfer, wraps CELL_AMOUNT-1 → 0. Counter only moves on transfer, never on stall.
- mode/shift/cap travel with the beat; changing them mid-stream affects only beats accepted afterwards.
- Simultaneous S2 transfer and S1 advance in the same cycle: S2 takes S1 content, no bubble.

Decomposition:
- Shared package: mode encodings (MODE_RELU=0, MODE_LEAKY=1, MODE_CLAMP=2, MODE_PASS=3), lane slice helper function.
- One sub-module: relu_lane_datapath (combinational S1 + saturate for one lane), instantiated LANES times via generate; handshake, pipeline registers and index counter in the top.

Test Plan:
- Reset then ReLU, LANES=2, output_ready=1: beats {1,-1},{-20,15} → 2 cycles later values {1,0} idx0 last0, then {0,15} idx1 last1; counter back to 0.
- Leaky, shift=2: lane {-20, 7} → {-5, 7}; shift=63 with -1 → -1.
- Clamp, cap=6: {10,-3} → {6,0}; pass mode {2^40,-2^40} → {2^31-1, -2^31}.
- Backpressure: stream 4 beats, output_ready low for 3 cycles after first output → output held stable, input_ready low once S1 full, all 4 beats emerge in order, indices 0,1,0,1.
- input_valid toggling with bubbles → output_enable 0 and value 0 in bubble cycles, index unchanged.
- Assert reset_n low between edges with 2 beats in flight → output_enable, output_last, value, index 0 immediately; post-reset beat reports idx0.

Source files
------------

// File: rtl/relu_stream_unit_pkg.sv
// Shared definitions for the relu_stream_unit activation stage.
// Mode encodings and the lane slicing helper used by the top and the lane datapath.
package relu_stream_unit_pkg;

    typedef enum logic [1:0] {
        MODE_RELU  = 2'd0,
        MODE_LEAKY = 2'd1,
        MODE_CLAMP = 2'd2,
        MODE_PASS  = 2'd3
    } mode_e;

    // LSB position of a lane inside a flat multi-lane bus.
    function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned width);
        return lane * width;
    endfunction

endpackage

// File: rtl/relu_lane_datapath.sv
// One lane of the activation stage: the S1 activation function and the S2 signed saturation.
// Both paths are purely combinational; the top owns the pipeline registers between them.
module relu_lane_datapath
    import relu_stream_unit_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int RESULT_WIDTH = 64,
    parameter int SHIFT_WIDTH  = 6
) (
    input  logic [RESULT_WIDTH-1:0] x_i,
    input  mode_e                   mode_i,
    input  logic [SHIFT_WIDTH-1:0]  shift_i,
    input  logic [DATA_WIDTH-1:0]   cap_i,
    output logic [RESULT_WIDTH-1:0] act_o,
    input  logic [RESULT_WIDTH-1:0] sat_i,
    output logic [DATA_WIDTH-1:0]   sat_o
);

    logic signed [RESULT_WIDTH-1:0] x;
    logic signed [RESULT_WIDTH-1:0] cap_ext;
    logic signed [RESULT_WIDTH-1:0] act;
    logic [RESULT_WIDTH-DATA_WIDTH:0] sat_hi;

    assign x       = $signed(x_i);
    assign cap_ext = $signed({{(RESULT_WIDTH-DATA_WIDTH){1'b0}}, cap_i});

    always_comb begin
        act = x;
        case (mode_i)
            MODE_RELU:  if (x < 0) act = '0;
            // Arithmetic shift saturates to -1 for large shifts on negative inputs.
            MODE_LEAKY: if (x < 0) act = x >>> shift_i;
            MODE_CLAMP: begin
                if (x < 0)            act = '0;
                else if (x > cap_ext) act = cap_ext;
            end
            default:    act = x;
        endcase
    end

    assign act_o = act;

    // In range exactly when every bit from the output sign bit upward matches.
    assign sat_hi = sat_i[RESULT_WIDTH-1:DATA_WIDTH-1];

    always_comb begin
        if ((&sat_hi) || !(|sat_hi))
            sat_o = sat_i[DATA_WIDTH-1:0];
        else if (sat_i[RESULT_WIDTH-1])
            sat_o = {1'b1, {(DATA_WIDTH-1){1'b0}}};
        else
            sat_o = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    end

endmodule

// File: rtl/relu_stream_unit.sv
// Multi-lane activation stage: S1 registers activated results, S2 registers saturated outputs.
// Valid/ready backpressure through both stages plus a wrapping per-group output index.
module relu_stream_unit
    import relu_stream_unit_pkg::*;
#(
    parameter int LANES        = 2,
    parameter int DATA_WIDTH   = 32,
    parameter int RESULT_WIDTH = 64,
    parameter int INDEX_WIDTH  = 34,
    parameter int CELL_AMOUNT  = 2,
    parameter int SHIFT_WIDTH  = 6
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [LANES*RESULT_WIDTH-1:0] input_result,
    input  logic                          input_valid,
    output logic                          input_ready,
    input  logic [1:0]                    mode,
    input  logic [SHIFT_WIDTH-1:0]        shift,
    input  logic [DATA_WIDTH-1:0]         cap,
    output logic [LANES*DATA_WIDTH-1:0]   output_value,
    output logic [INDEX_WIDTH-1:0]        output_index,
    output logic                          output_enable,
    output logic                          output_last,
    input  logic                          output_ready
);

    localparam logic [INDEX_WIDTH-1:0] IDX_LAST = INDEX_WIDTH'(CELL_AMOUNT - 1);

    logic [LANES*RESULT_WIDTH-1:0] act_w;
    logic [LANES*DATA_WIDTH-1:0]   sat_w;
    logic [LANES*RESULT_WIDTH-1:0] s1_data_d, s1_data_q;
    logic [LANES*DATA_WIDTH-1:0]   s2_data_d, s2_data_q;
    logic                          s1_valid_d, s1_valid_q;
    logic                          s2_valid_d, s2_valid_q;
    logic [INDEX_WIDTH-1:0]        idx_d, idx_q;
    logic                          s1_load, s2_load, out_xfer;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        relu_lane_datapath #(
            .DATA_WIDTH  (DATA_WIDTH),
            .RESULT_WIDTH(RESULT_WIDTH),
            .SHIFT_WIDTH (SHIFT_WIDTH)
        ) u_lane (
            .x_i    (input_result[lane_lsb(g, RESULT_WIDTH) +: RESULT_WIDTH]),
            .mode_i (mode_e'(mode)),
            .shift_i(shift),
            .cap_i  (cap),
            .act_o  (act_w[lane_lsb(g, RESULT_WIDTH) +: RESULT_WIDTH]),
            .sat_i  (s1_data_q[lane_lsb(g, RESULT_WIDTH) +: RESULT_WIDTH]),
            .sat_o  (sat_w[lane_lsb(g, DATA_WIDTH) +: DATA_WIDTH])
        );
    end

    // Mode/shift/cap act at acceptance, so the beat carries its own configuration.
    always_comb begin
        s2_load    = !s2_valid_q || output_ready;
        s1_load    = !s1_valid_q || s2_load;
        out_xfer   = s2_valid_q && output_ready;
        s1_valid_d = s1_valid_q;
        s1_data_d  = s1_data_q;
        s2_valid_d = s2_valid_q;
        s2_data_d  = s2_data_q;
        idx_d      = idx_q;
        if (s1_load) begin
            s1_valid_d = input_valid;
            if (input_valid) s1_data_d = act_w;
        end
        if (s2_load) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) s2_data_d = sat_w;
        end
        if (out_xfer) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            idx_q      <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_data_q  <= s1_data_d;
            s2_valid_q <= s2_valid_d;
            s2_data_q  <= s2_data_d;
            idx_q      <= idx_d;
        end
    end

    assign input_ready   = s1_load;
    assign output_enable = s2_valid_q;
    assign output_value  = s2_valid_q ? s2_data_q : '0;
    assign output_index  = idx_q;
    assign output_last   = s2_valid_q && (idx_q == IDX_LAST);

endmodule

// File: tb/tb_relu_stream_unit.sv
// Scoreboard bench for relu_stream_unit: a reference model pushes expected beats on
// acceptance, and each scenario task pops and compares them as outputs transfer.
module tb_relu_stream_unit;

    localparam int LANES = 2;
    localparam int DW    = 32;
    localparam int RW    = 64;
    localparam int IW    = 34;
    localparam int CA    = 2;
    localparam int SW    = 6;

    typedef struct packed {
        logic [LANES*RW-1:0] d;
        logic [1:0]          m;
        logic [SW-1:0]       sh;
        logic [DW-1:0]       cp;
    } beat_t;

    logic                clk = 1'b0;
    logic                reset_n;
    logic [LANES*RW-1:0] input_result;
    logic                input_valid;
    logic                input_ready;
    logic [1:0]          mode;
    logic [SW-1:0]       shift;
    logic [DW-1:0]       cap;
    logic [LANES*DW-1:0] output_value;
    logic [IW-1:0]       output_index;
    logic                output_enable;
    logic                output_last;
    logic                output_ready;

    logic [LANES*DW-1:0] sb[$];
    int                  exp_idx;
    int                  n_checks;
    int                  n_pass;

    relu_stream_unit dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .input_result (input_result),
        .input_valid  (input_valid),
        .input_ready  (input_ready),
        .mode         (mode),
        .shift        (shift),
        .cap          (cap),
        .output_value (output_value),
        .output_index (output_index),
        .output_enable(output_enable),
        .output_last  (output_last),
        .output_ready (output_ready)
    );

    always #5 clk = ~clk;

    function automatic beat_t mk(input longint a, input longint b, input logic [1:0] m,
                                 input logic [SW-1:0] sh, input logic [DW-1:0] cp);
        beat_t r;
        r.d  = {b, a};
        r.m  = m;
        r.sh = sh;
        r.cp = cp;
        return r;
    endfunction

    function automatic logic [LANES*DW-1:0] model(input beat_t b);
        logic [LANES*DW-1:0] r;
        logic signed [RW-1:0] x, y;
        r = '0;
        for (int k = 0; k < LANES; k++) begin
            x = b.d[k*RW +: RW];
            case (b.m)
                2'd0: y = (x < 0) ? 64'sd0 : x;
                2'd1: y = (x < 0) ? (x >>> b.sh) : x;
                2'd2: y = (x < 0) ? 64'sd0 : ((x > $signed({32'b0, b.cp})) ? $signed({32'b0, b.cp}) : x);
                default: y = x;
            endcase
            if (y > 64'sd2147483647)       r[k*DW +: DW] = 32'h7fff_ffff;
            else if (y < -64'sd2147483648) r[k*DW +: DW] = 32'h8000_0000;
            else                           r[k*DW +: DW] = y[DW-1:0];
        end
        return r;
    endfunction

    task automatic drive_cycle(input logic v, input beat_t b, input logic ordy);
        @(negedge clk);
        input_valid  = v;
        input_result = b.d;
        mode         = b.m;
        shift        = b.sh;
        cap          = b.cp;
        output_ready = ordy;
        #1;
        if (v && input_ready) sb.push_back(model(b));
    endtask

    task automatic test_reset;
        reset_n      = 1'b0;
        input_valid  = 1'b0;
        input_result = '0;
        mode         = 2'd0;
        shift        = '0;
        cap          = '0;
        output_ready = 1'b1;
        exp_idx      = 0;
        #22;
        n_checks++; if (output_enable !== 1'b0) $display("FAIL reset_enable got %b expected 0", output_enable); else n_pass++;
        n_checks++; if (output_last !== 1'b0) $display("FAIL reset_last got %b expected 0", output_last); else n_pass++;
        n_checks++; if (output_value !== '0) $display("FAIL reset_value got %h expected 0", output_value); else n_pass++;
        n_checks++; if (output_index !== '0) $display("FAIL reset_index got %0d expected 0", output_index); else n_pass++;
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        n_checks++; if (input_ready !== 1'b1) $display("FAIL reset_input_ready got %b expected 1", input_ready); else n_pass++;
    endtask

    task automatic test_relu;
        beat_t b[$];
        beat_t idle;
        logic [LANES*DW-1:0] e;
        int first;
        idle  = '0;
        first = -1;
        b.push_back(mk(1, -1, 2'd0, 0, 0));
        b.push_back(mk(-20, 15, 2'd0, 0, 0));
        for (int c = 0; c < 12; c++) begin
            drive_cycle(c < b.size(), (c < b.size()) ? b[c] : idle, 1'b1);
            if (output_enable && first < 0) first = c;
            if (output_enable && output_ready) begin
                n_checks++;
                if (sb.size() == 0) $display("FAIL relu_unexpected got %h expected none", output_value);
                else begin
                    e = sb.pop_front();
                    if (output_value !== e || output_index !== IW'(exp_idx) || output_last !== (exp_idx == CA-1))
                        $display("FAIL relu_out got v=%h idx=%0d last=%b expected v=%h idx=%0d last=%b",
                                 output_value, output_index, output_last, e, exp_idx, exp_idx == CA-1);
                    else n_pass++;
                    exp_idx = (exp_idx + 1) % CA;
                end
            end
        end
        n_checks++; if (first !== 2) $display("FAIL relu_latency got %0d expected 2", first); else n_pass++;
        n_checks++; if (sb.size() != 0) $display("FAIL relu_drain got %0d pending expected 0", sb.size()); else n_pass++;
        n_checks++; if (output_index !== '0) $display("FAIL relu_index_wrap got %0d expected 0", output_index); else n_pass++;
    endtask

    task automatic test_leaky_clamp_pass;
        beat_t b[$];
        beat_t idle;
        logic [LANES*DW-1:0] e;
        idle = '0;
        b.push_back(mk(-20, 7, 2'd1, 6'd2, 0));
        b.push_back(mk(-1, -1000, 2'd1, 6'd63, 0));
        b.push_back(mk(10, -3, 2'd2, 0, 32'd6));
        b.push_back(mk(6, 5, 2'd2, 0, 32'd6));
        b.push_back(mk(64'sh100_0000_0000, -64'sh100_0000_0000, 2'd3, 0, 0));
        b.push_back(mk(64'sh100_0000_0000, -7, 2'd0, 0, 0));
        for (int c = 0; c < 20; c++) begin
            drive_cycle(c < b.size(), (c < b.size()) ? b[c] : idle, 1'b1);
            if (output_enable && output_ready) begin
                n_checks++;
                if (sb.size() == 0) $display("FAIL modes_unexpected got %h expected none", output_value);
                else begin
                    e = sb.pop_front();
                    if (output_value !== e || output_index !== IW'(exp_idx) || output_last !== (exp_idx == CA-1))
                        $display("FAIL modes_out got v=%h idx=%0d last=%b expected v=%h idx=%0d last=%b",
                                 output_value, output_index, output_last, e, exp_idx, exp_idx == CA-1);
                    else n_pass++;
                    exp_idx = (exp_idx + 1) % CA;
                end
            end
        end
        n_checks++; if (sb.size() != 0) $display("FAIL modes_drain got %0d pending expected 0", sb.size()); else n_pass++;
    endtask

    task automatic test_backpressure;
        beat_t b[$];
        beat_t idle;
        logic [LANES*DW-1:0] e, held_v;
        logic [IW-1:0] held_i;
        logic ordy;
        int bi;
        idle = '0;
        bi   = 0;
        b.push_back(mk(100, -4, 2'd0, 0, 0));
        b.push_back(mk(-9, 200, 2'd3, 0, 0));
        b.push_back(mk(300, 301, 2'd0, 0, 0));
        b.push_back(mk(-5, -6, 2'd3, 0, 0));
        for (int c = 0; c < 24; c++) begin
            ordy = !(c >= 3 && c <= 5);
            drive_cycle(bi < b.size(), (bi < b.size()) ? b[bi] : idle, ordy);
            if (input_valid && input_ready) bi++;
            if (c == 3) begin
                held_v = output_value;
                held_i = output_index;
            end
            if (c >= 3 && c <= 5) begin
                n_checks++;
                if (output_enable !== 1'b1 || output_value !== held_v || output_index !== held_i)
                    $display("FAIL bp_hold cycle %0d got en=%b v=%h idx=%0d expected en=1 v=%h idx=%0d",
                             c, output_enable, output_value, output_index, held_v, held_i);
                else n_pass++;
                n_checks++;
                if (input_ready !== 1'b0) $display("FAIL bp_input_ready cycle %0d got %b expected 0", c, input_ready);
                else n_pass++;
            end
            if (output_enable && output_ready) begin
                n_checks++;
                if (sb.size() == 0) $display("FAIL bp_unexpected got %h expected none", output_value);
                else begin
                    e = sb.pop_front();
                    if (output_value !== e || output_index !== IW'(exp_idx) || output_last !== (exp_idx == CA-1))
                        $display("FAIL bp_out got v=%h idx=%0d last=%b expected v=%h idx=%0d last=%b",
                                 output_value, output_index, output_last, e, exp_idx, exp_idx == CA-1);
                    else n_pass++;
                    exp_idx = (exp_idx + 1) % CA;
                end
            end
        end
        n_checks++; if (bi != 4 || sb.size() != 0) $display("FAIL bp_drain got sent=%0d pending=%0d expected 4 and 0", bi, sb.size()); else n_pass++;
    endtask

    task automatic test_bubbles;
        beat_t b[$];
        beat_t idle;
        logic [LANES*DW-1:0] e;
        int bi;
        idle = '0;
        bi   = 0;
        b.push_back(mk(11, -12, 2'd0, 0, 0));
        b.push_back(mk(-64, 13, 2'd1, 6'd3, 0));
        b.push_back(mk(50, 2, 2'd2, 0, 32'd40));
        b.push_back(mk(-2, 3, 2'd3, 0, 0));
        for (int c = 0; c < 16; c++) begin
            drive_cycle((c % 2 == 0) && bi < b.size(), (bi < b.size()) ? b[bi] : idle, 1'b1);
            if (input_valid && input_ready) bi++;
            if (!output_enable) begin
                n_checks++;
                if (output_value !== '0 || output_last !== 1'b0 || output_index !== IW'(exp_idx))
                    $display("FAIL bubble_idle cycle %0d got v=%h last=%b idx=%0d expected v=0 last=0 idx=%0d",
                             c, output_value, output_last, output_index, exp_idx);
                else n_pass++;
            end
            if (output_enable && output_ready) begin
                n_checks++;
                if (sb.size() == 0) $display("FAIL bubble_unexpected got %h expected none", output_value);
                else begin
                    e = sb.pop_front();
                    if (output_value !== e || output_index !== IW'(exp_idx) || output_last !== (exp_idx == CA-1))
                        $display("FAIL bubble_out got v=%h idx=%0d last=%b expected v=%h idx=%0d last=%b",
                                 output_value, output_index, output_last, e, exp_idx, exp_idx == CA-1);
                    else n_pass++;
                    exp_idx = (exp_idx + 1) % CA;
                end
            end
        end
        n_checks++; if (bi != 4 || sb.size() != 0) $display("FAIL bubble_drain got sent=%0d pending=%0d expected 4 and 0", bi, sb.size()); else n_pass++;
    endtask

    task automatic test_reset_midstream;
        beat_t b[$];
        beat_t idle;
        logic [LANES*DW-1:0] e;
        idle = '0;
        b.push_back(mk(1, 2, 2'd3, 0, 0));
        b.push_back(mk(3, 4, 2'd3, 0, 0));
        b.push_back(mk(5, 6, 2'd3, 0, 0));
        for (int c = 0; c < 3; c++) drive_cycle(1'b1, b[c], 1'b1);
        @(posedge clk);
        #2;
        input_valid = 1'b0;
        n_checks++;
        if (output_enable !== 1'b1 || output_index !== IW'(1))
            $display("FAIL rst_precond got en=%b idx=%0d expected en=1 idx=1", output_enable, output_index);
        else n_pass++;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (output_enable !== 1'b0 || output_last !== 1'b0 || output_value !== '0 || output_index !== '0)
            $display("FAIL rst_mid got en=%b last=%b v=%h idx=%0d expected all 0",
                     output_enable, output_last, output_value, output_index);
        else n_pass++;
        sb.delete();
        exp_idx = 0;
        @(negedge clk);
        reset_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            drive_cycle(c == 0, (c == 0) ? mk(-8, 9, 2'd0, 0, 0) : idle, 1'b1);
            if (output_enable && output_ready) begin
                n_checks++;
                if (sb.size() == 0) $display("FAIL rst_unexpected got %h expected none", output_value);
                else begin
                    e = sb.pop_front();
                    if (output_value !== e || output_index !== IW'(exp_idx) || output_last !== (exp_idx == CA-1))
                        $display("FAIL rst_out got v=%h idx=%0d last=%b expected v=%h idx=%0d last=%b",
                                 output_value, output_index, output_last, e, exp_idx, exp_idx == CA-1);
                    else n_pass++;
                    exp_idx = (exp_idx + 1) % CA;
                end
            end
        end
        n_checks++; if (sb.size() != 0) $display("FAIL rst_drain got %0d pending expected 0", sb.size()); else n_pass++;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        test_reset;
        test_relu;
        test_leaky_clamp_pass;
        test_backpressure;
        test_bubbles;
        test_reset_midstream;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
